// File: rtl/mem_test_pkg.sv
// Shared types and default sizing for the memory test sequencer.
package mem_test_pkg;

    localparam int DEF_AW        = 16;
    localparam int DEF_DW        = 16;
    localparam int DEF_BURST_MAX = 10;

    typedef enum logic [2:0] {
        ST_ADDR,
        ST_DATA,
        ST_LEN,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_test_addr_gen.sv
// Burst index counter producing base+idx address, seed+idx pattern and last-beat flag.
module mem_test_addr_gen #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic [AW-1:0] i_base,
    input  logic [DW-1:0] i_seed,
    input  logic [CW-1:0] i_len,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata,
    output logic          o_last
);

    logic [CW-1:0] r_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_idx <= '0;
        else if (i_clr) r_idx <= '0;
        else if (i_inc) r_idx <= r_idx + 1'b1;
    end

    // Sums wrap naturally at the destination width.
    assign o_addr  = i_base + AW'(r_idx);
    assign o_wdata = i_seed + DW'(r_idx);
    assign o_last  = (r_idx == i_len - 1'b1);

endmodule

// File: rtl/mem_test_seq.sv
// Operator-driven write-then-readback memory burst sequencer.
// Define MEM_TEST_SEQ_CHECK_EN to add readback compare outputs err_cnt/err_flag.
module mem_test_seq
    import mem_test_pkg::*;
#(
    parameter  int AW        = DEF_AW,
    parameter  int DW        = DEF_DW,
    parameter  int BURST_MAX = DEF_BURST_MAX,
    localparam int CW        = $clog2(BURST_MAX + 1),
    localparam int SW        = (AW > DW) ? AW : DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] sw_in,
    input  logic          step,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
`ifdef MEM_TEST_SEQ_CHECK_EN
    output logic [CW-1:0] err_cnt,
    output logic          err_flag,
`endif
    output logic          done
);

    state_t        r_state, w_next;
    logic [AW-1:0] r_base;
    logic [DW-1:0] r_seed;
    logic [CW-1:0] r_len;
    logic [CW-1:0] w_len_raw, w_len_sat;
    logic          w_cap_base, w_cap_seed, w_cap_len;
    logic          w_last, w_clr, w_inc;
    logic [DW-1:0] w_wdata;

    assign w_len_raw = sw_in[CW-1:0];

    always_comb begin
        w_len_sat = w_len_raw;
        if (w_len_raw == '0)                    w_len_sat = CW'(1);
        else if (w_len_raw > CW'(BURST_MAX))    w_len_sat = CW'(BURST_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_ADDR;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        w_cap_base = 1'b0;
        w_cap_seed = 1'b0;
        w_cap_len  = 1'b0;
        case (r_state)
            ST_ADDR: if (step) begin w_cap_base = 1'b1; w_next = ST_DATA; end
            ST_DATA: if (step) begin w_cap_seed = 1'b1; w_next = ST_LEN;  end
            ST_LEN:  if (step) begin w_cap_len  = 1'b1; w_next = ST_WRITE; end
            ST_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (mem_ack && w_last) w_next = ST_READ;
            end
            ST_READ: begin
                mem_re = 1'b1;
                busy   = 1'b1;
                if (mem_ack && w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (step) w_next = ST_ADDR;
            end
            default: w_next = ST_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base <= '0;
            r_seed <= '0;
            r_len  <= CW'(1);
        end else begin
            if (w_cap_base) r_base <= sw_in[AW-1:0];
            if (w_cap_seed) r_seed <= sw_in[DW-1:0];
            if (w_cap_len)  r_len  <= w_len_sat;
        end
    end

    // Index restarts for the read pass and again at the next burst.
    assign w_inc = busy & mem_ack;
    assign w_clr = w_cap_len | (w_inc & w_last);

    mem_test_addr_gen #(.AW(AW), .DW(DW), .CW(CW)) u_gen (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .i_base  (r_base),
        .i_seed  (r_seed),
        .i_len   (r_len),
        .o_addr  (mem_addr),
        .o_wdata (w_wdata),
        .o_last  (w_last)
    );

    assign mem_wdata = w_wdata;

`ifdef MEM_TEST_SEQ_CHECK_EN
    logic [CW-1:0] r_err_cnt;
    logic          r_err_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else if (w_cap_len) begin
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else if (mem_re && mem_ack && (mem_rdata != w_wdata)) begin
            r_err_flag <= 1'b1;
            if (r_err_cnt != CW'(BURST_MAX)) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt  = r_err_cnt;
    assign err_flag = r_err_flag;
`endif

endmodule
